// File: rtl/result_drain.sv
// result_drain: captures one NxN product matrix (row-major) into a single buffer,
// then drains it as a valid/ready stream tagged with row/column indices.
module result_drain #(
   parameter int unsigned DW = 10,
   parameter int unsigned N  = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          res_valid,
   input  logic [DW-1:0] res_data,
   input  logic          res_last,
   output logic          res_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [1:0]    out_row,
   output logic [1:0]    out_col,
   input  logic          out_ready,
   output logic          done,
   output logic          err
);

   localparam int unsigned NE = N * N;
   localparam int unsigned CW = $clog2(NE);

   typedef enum logic {
      FILL,
      DRAIN
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;
   logic [DW-1:0] buffer [NE];
   logic          accept;
   logic          xfer;
   logic          wr_last;
   logic          rd_last;

   assign res_ready = (state == FILL);
   assign out_valid = (state == DRAIN);
   assign accept    = res_valid && res_ready;
   assign xfer      = out_ready && out_valid;
   assign wr_last   = (wr_cnt == CW'(NE - 1));
   assign rd_last   = (rd_cnt == CW'(NE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = FILL;
      end else begin
         unique case (state)
            FILL:    if (accept && wr_last) state_next = DRAIN;
            DRAIN:   if (xfer && rd_last)   state_next = FILL;
            default: state_next = FILL;
         endcase
      end
   end

   // out_* are preloaded with element 0 on the final accept so the first DRAIN
   // cycle already presents valid registered data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         buffer   <= '{default: '0};
         out_data <= '0;
         out_row  <= '0;
         out_col  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else if (clear) begin
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         out_data <= '0;
         out_row  <= '0;
         out_col  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            buffer[wr_cnt] <= res_data;
            wr_cnt         <= wr_last ? '0 : wr_cnt + 1'b1;
            if (res_last != wr_last) err <= 1'b1;
            if (wr_last) begin
               out_data <= buffer[0];
               out_row  <= '0;
               out_col  <= '0;
            end
         end
         if (xfer) begin
            if (rd_last) begin
               rd_cnt <= '0;
               done   <= 1'b1;
            end else begin
               rd_cnt   <= rd_cnt + 1'b1;
               out_data <= buffer[rd_cnt + 1'b1];
               if (out_col == 2'(N - 1)) begin
                  out_col <= '0;
                  out_row <= out_row + 1'b1;
               end else begin
                  out_col <= out_col + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: random matrices, backpressure, marker errors,
// clear and mid-drain reset, checked against a queue-based reference model.
module tb_result_drain;

   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          res_valid = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          res_last = 1'b0;
   logic          res_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_row;
   logic [1:0]    out_col;
   logic          out_ready = 1'b0;
   logic          done;
   logic          err;

   result_drain #(.DW(DW), .N(3)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
      .res_ready(res_ready), .out_valid(out_valid), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_ready(out_ready),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int row;
      int col;
      int data;
   } elem_t;

   elem_t q[$];
   int    tests = 0;
   int    fails = 0;
   bit    draining = 0;
   bit    done_exp = 0;
   bit    exp_err = 0;
   bit    mon_en = 0;
   bit    run = 1;
   int    pops = 0;
   int    rdy_mode = 0;
   int    vals[9];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name, input int cycles);
      tests++;
      fails++;
      $display("FAIL %s: no progress after %0d cycles", name, cycles);
   endtask

   task automatic rand_vals();
      for (int i = 0; i < 9; i++) vals[i] = $urandom_range(0, 675);
   endtask

   // consumer ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random
   initial begin
      int ph = 0;
      while (run) begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ph % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("res_ready", int'(res_ready), int'(!draining));
         chk("out_valid", int'(out_valid), int'(draining));
         chk("done", int'(done), int'(done_exp));
         chk("err", int'(err), int'(exp_err));
         done_exp = 0;
         if (out_valid && q.size() > 0) begin
            chk("out_data", int'(out_data), q[0].data);
            chk("out_row", int'(out_row), q[0].row);
            chk("out_col", int'(out_col), q[0].col);
            if (out_ready) begin
               void'(q.pop_front());
               pops++;
               if (q.size() == 0) begin
                  draining = 0;
                  done_exp = 1;
               end
            end
         end
      end
   end

   task automatic feed(input int gap, input int bad_idx, input int clr_idx);
      int k = 0;
      bit cleared = 0;
      bit r;
      int budget;
      elem_t e;
      while (k < 9) begin
         repeat ($urandom_range(0, gap)) begin
            res_valid = 1'b0;
            res_last  = 1'($urandom_range(0, 1));
            res_data  = DW'($urandom);
            @(posedge clk);
            #1;
         end
         res_valid = 1'b1;
         res_data  = DW'(vals[k]);
         res_last  = (k == 8) != (k == bad_idx);
         if (k == clr_idx && !cleared) begin
            clear = 1'b1;
            @(posedge clk);
            exp_err = 0;
            #1;
            clear     = 1'b0;
            res_valid = 1'b0;
            cleared   = 1;
            k = 0;
            rand_vals();
            continue;
         end
         r = 0;
         budget = 0;
         while (!r && budget < 400) begin
            @(negedge clk);
            r = res_ready;
            @(posedge clk);
            budget++;
         end
         if (!r) begin
            timeout_fail("accept_timeout", budget);
            res_valid = 1'b0;
            return;
         end
         if (res_last != (k == 8)) exp_err = 1;
         k++;
         if (k == 9) begin
            for (int i = 0; i < 9; i++) begin
               e.row  = i / 3;
               e.col  = i % 3;
               e.data = vals[i];
               q.push_back(e);
            end
            draining = 1;
         end
         #1;
      end
      res_valid = 1'b0;
      res_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int budget = 0;
      while ((draining || q.size() > 0) && budget < 500) begin
         @(posedge clk);
         budget++;
      end
      if (budget >= 500) timeout_fail("drain_timeout", budget);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      int budget;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_ready", int'(res_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      rst_n  = 1'b1;
      mon_en = 1;

      rdy_mode = 0;
      for (int i = 0; i < 9; i++) vals[i] = i + 1;
      feed(0, -1, -1);
      wait_idle();

      // second feed holds res_valid high while the first matrix drains
      rdy_mode = 1;
      rand_vals();
      feed(0, -1, -1);
      rand_vals();
      feed(0, -1, -1);
      wait_idle();

      rdy_mode = 2;
      for (int i = 0; i < 9; i++) vals[i] = 675;
      feed(4, -1, -1);
      wait_idle();

      rdy_mode = 0;
      rand_vals();
      feed(1, 4, -1);
      wait_idle();
      rand_vals();
      feed(1, -1, -1);
      wait_idle();
      clear = 1'b1;
      @(posedge clk);
      exp_err = 0;
      #1;
      clear = 1'b0;

      rand_vals();
      feed(1, -1, 5);
      wait_idle();

      for (int t = 0; t < 6; t++) begin
         rdy_mode = 2;
         rand_vals();
         feed(3, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1, -1);
      end
      wait_idle();

      rdy_mode = 0;
      rand_vals();
      p0 = pops;
      feed(0, -1, -1);
      budget = 0;
      while (pops < p0 + 4 && budget < 100) begin
         @(posedge clk);
         #3;
         budget++;
      end
      if (pops < p0 + 4) timeout_fail("reset_wait", budget);
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_res_ready", int'(res_ready), 1);
      chk("mid_rst_out_data", int'(out_data), 0);
      chk("mid_rst_out_row", int'(out_row), 0);
      chk("mid_rst_out_col", int'(out_col), 0);
      chk("mid_rst_done", int'(done), 0);
      q.delete();
      draining = 0;
      done_exp = 0;
      exp_err  = 0;
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1;
      rand_vals();
      feed(2, -1, -1);
      wait_idle();

      run = 0;
      mon_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
